// File: rtl/text_pkg.sv
// Shared ASCII constants, editor state type and character classification
// for the VGA text line buffer.
package text_pkg;

    localparam logic [7:0] ASCII_FILL   = 8'h20;
    localparam logic [7:0] ASCII_CURSOR = 8'h5F;
    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_ESC    = 8'h1B;
    localparam logic [7:0] PRINT_LO     = 8'h20;
    localparam logic [7:0] PRINT_HI     = 8'h7E;

    typedef enum logic {
        EDIT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/frame_blink_counter.sv
// Free-running frame counter advanced by frame_start; its MSB drives the
// cursor blink with a 50% duty cycle.
module frame_blink_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (frame_start) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/text_line_buffer.sv
// One-line edit buffer fed by the keyboard decoder; the line (plus a blinking
// cursor) is copied to s1 only on frame_start so the renderer sees whole edits.
module text_line_buffer
    import text_pkg::*;
#(
    parameter int         N_CHARS     = 31,
    parameter logic [7:0] FILL_CHAR   = ASCII_FILL,
    parameter logic [7:0] CURSOR_CHAR = ASCII_CURSOR,
    parameter int         BLINK_LOG2  = 5
) (
    input  logic                 VGA_CLK_IN,
    input  logic                 rst_n,
    input  logic                 char_valid,
    input  logic [7:0]           char_data,
    output logic                 char_ready,
    input  logic                 frame_start,
    output logic [N_CHARS*8-1:0] s1,
    output logic [4:0]           length,
    output logic                 line_done,
    output logic                 overflow
);

    localparam logic [4:0] LEN_MAX = 5'(N_CHARS);

    state_t                 state_q, state_d;
    logic [7:0]             buf_q [N_CHARS];
    logic [7:0]             buf_d [N_CHARS];
    logic [4:0]             length_q, length_d;
    logic                   ready_q;
    logic                   line_done_q, line_done_d;
    logic                   overflow_q, overflow_d;
    logic [N_CHARS*8-1:0]   s1_q, s1_d;
    logic [N_CHARS*8-1:0]   snap;
    logic [BLINK_LOG2-1:0]  blink_count;
    logic                   accept;
    logic                   cursor_on;

    frame_blink_counter #(
        .WIDTH(BLINK_LOG2)
    ) u_blink (
        .clk        (VGA_CLK_IN),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .count      (blink_count)
    );

    // The publish copy owns the cycle, so input is stalled while frame_start is high.
    assign char_ready = ready_q && !frame_start;
    assign accept     = char_valid && char_ready;

    always_ff @(posedge VGA_CLK_IN) begin
        if (!rst_n) begin
            state_q     <= EDIT;
            length_q    <= '0;
            ready_q     <= 1'b0;
            line_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            s1_q        <= {N_CHARS{FILL_CHAR}};
            for (int i = 0; i < N_CHARS; i++) begin
                buf_q[i] <= FILL_CHAR;
            end
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            ready_q     <= 1'b1;
            line_done_q <= line_done_d;
            overflow_q  <= overflow_d;
            s1_q        <= s1_d;
            for (int i = 0; i < N_CHARS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                EDIT:    if (char_data == ASCII_CR)  state_d = LOCKED;
                LOCKED:  if (char_data == ASCII_ESC) state_d = EDIT;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        buf_d       = buf_q;
        length_d    = length_q;
        line_done_d = 1'b0;
        overflow_d  = 1'b0;
        if (accept) begin
            if (char_data == ASCII_ESC) begin
                for (int i = 0; i < N_CHARS; i++) begin
                    buf_d[i] = FILL_CHAR;
                end
                length_d = '0;
            end else if (state_q == EDIT) begin
                if (is_printable(char_data)) begin
                    if (length_q < LEN_MAX) begin
                        buf_d[length_q] = char_data;
                        length_d        = length_q + 5'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (char_data == ASCII_BS) begin
                    if (length_q != '0) begin
                        buf_d[length_q - 5'd1] = FILL_CHAR;
                        length_d               = length_q - 5'd1;
                    end
                end else if (char_data == ASCII_CR) begin
                    line_done_d = 1'b1;
                end
            end
        end
    end

    // Cursor is overlaid on the snapshot only; the edit buffer never holds it.
    assign cursor_on = (state_q == EDIT) && (length_q < LEN_MAX) && !blink_count[BLINK_LOG2-1];

    generate
        for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_snap
            assign snap[(N_CHARS-1-gi)*8 +: 8] =
                (cursor_on && (length_q == 5'(gi))) ? CURSOR_CHAR : buf_q[gi];
        end
    endgenerate

    always_comb begin
        s1_d = s1_q;
        if (frame_start) begin
            s1_d = snap;
        end
    end

    assign s1        = s1_q;
    assign length    = length_q;
    assign line_done = line_done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_text_line_buffer.sv
// Directed plus randomized bench for text_line_buffer, checked every cycle
// against a queue-based model of the edit line, lock flag and frame counter.
module tb_text_line_buffer;

    localparam int N = 31;
    localparam int W = N * 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         char_valid = 1'b0;
    logic [7:0]   char_data = 8'h00;
    logic         frame_start = 1'b0;
    logic         char_ready;
    logic [W-1:0] s1;
    logic [4:0]   length;
    logic         line_done;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0]   m_line[$];
    bit           m_locked;
    bit           m_ready;
    int           m_cnt;
    logic [W-1:0] exp_s1;
    logic         exp_ov;
    logic         exp_ld;
    bit           last_acc;

    logic         r_v;
    logic [7:0]   r_d;
    logic         r_fs;

    always #5 clk = ~clk;

    text_line_buffer dut (
        .VGA_CLK_IN (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .frame_start(frame_start),
        .s1         (s1),
        .length     (length),
        .line_done  (line_done),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line as the renderer should see it: typed text, cursor after it, spaces.
    function automatic logic [W-1:0] snapshot();
        logic [W-1:0] s;
        logic [7:0]   c;
        bit           cur;
        cur = !m_locked && (m_line.size() < N) && (m_cnt < 16);
        for (int i = 0; i < N; i++) begin
            if (i < m_line.size())               c = m_line[i];
            else if (i == m_line.size() && cur)  c = 8'h5F;
            else                                 c = 8'h20;
            s[(N-1-i)*8 +: 8] = c;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_line.delete();
        m_locked = 0;
        m_ready  = 0;
        m_cnt    = 0;
        exp_s1   = {N{8'h20}};
        exp_ov   = 0;
        exp_ld   = 0;
        last_acc = 0;
    endtask

    task automatic apply(input logic [7:0] d);
        if (d == 8'h1B) begin
            m_line.delete();
            m_locked = 0;
        end else if (!m_locked) begin
            if (d >= 8'h20 && d <= 8'h7E) begin
                if (m_line.size() < N) m_line.push_back(d);
                else exp_ov = 1;
            end else if (d == 8'h08) begin
                if (m_line.size() > 0) void'(m_line.pop_back());
            end else if (d == 8'h0D) begin
                m_locked = 1;
                exp_ld   = 1;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic fs);
        bit acc;
        char_valid  = v;
        char_data   = d;
        frame_start = fs;
        #1;
        chk("char_ready", W'(char_ready), W'(m_ready && !fs));
        acc    = v && m_ready && !fs;
        exp_ov = 0;
        exp_ld = 0;
        if (fs) begin
            exp_s1 = snapshot();
            m_cnt  = (m_cnt + 1) % 32;
        end
        if (acc) apply(d);
        last_acc = acc;
        m_ready  = 1;
        @(posedge clk);
        #1;
        if (acc) $display("[TB] t=%0t accepted %02h length=%0d", $time, d, length);
        chk("length", W'(length), W'(m_line.size()));
        chk("overflow", W'(overflow), W'(exp_ov));
        chk("line_done", W'(line_done), W'(exp_ld));
        chk("s1", s1, exp_s1);
    endtask

    task automatic do_reset(input int n);
        rst_n       = 0;
        char_valid  = 0;
        frame_start = 0;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_char_ready", W'(char_ready), W'(0));
            chk("rst_length", W'(length), W'(0));
            chk("rst_s1", s1, exp_s1);
            chk("rst_overflow", W'(overflow), W'(0));
            chk("rst_line_done", W'(line_done), W'(0));
        end
        rst_n = 1;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70)      return 8'($urandom_range(8'h20, 8'h7E));
        else if (r < 78) return 8'h08;
        else if (r < 82) return 8'h0D;
        else if (r < 87) return 8'h1B;
        else             return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        do_reset(3);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        cyc(1, 8'h48, 0);
        cyc(1, 8'h69, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        cyc(1, 8'h1B, 0);
        repeat (31) cyc(1, 8'h41, 0);
        cyc(1, 8'h42, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        cyc(1, 8'h1B, 0);
        cyc(1, 8'h61, 0);
        cyc(1, 8'h62, 0);
        cyc(1, 8'h63, 0);
        cyc(1, 8'h08, 0);
        cyc(1, 8'h08, 0);
        cyc(0, 8'h00, 1);
        cyc(1, 8'h08, 0);
        cyc(1, 8'h08, 0);
        cyc(0, 8'h00, 1);

        cyc(1, 8'h5A, 0);
        cyc(1, 8'h0D, 0);
        cyc(0, 8'h00, 0);
        cyc(1, 8'h58, 0);
        cyc(0, 8'h00, 1);
        cyc(1, 8'h1B, 0);
        cyc(0, 8'h00, 1);

        cyc(1, 8'h51, 1);
        cyc(1, 8'h51, 0);
        cyc(0, 8'h00, 0);

        for (int k = 0; k < 32; k++) begin
            cyc(0, 8'h00, 1);
            cyc(0, 8'h00, 0);
        end

        r_v = 0;
        r_d = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) do_reset(2);
            if (!(r_v && !last_acc)) begin
                r_v = ($urandom_range(0, 9) < 6);
                r_d = rand_char();
            end
            r_fs = ($urandom_range(0, 99) < 8);
            cyc(r_v, r_d, r_fs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
